// File: rtl/ntt_bram_pkg.sv
// Shared constants and types for the NTT BRAM responder: widths, CSR word index,
// CSR bit positions and the packed status struct.
package ntt_bram_pkg;

    localparam int DEF_ADDR_W   = 13;
    localparam int DEF_DATA_W   = 64;
    localparam int CSR_WORD_IDX = 1023;

    // Status bit positions on CSR read
    localparam int CSR_BUSY = 0;
    localparam int CSR_DONE = 1;
    localparam int CSR_OVF  = 2;

    // Command bit positions on CSR write
    localparam int CSR_START    = 0;
    localparam int CSR_W1C_DONE = 1;
    localparam int CSR_W1C_OVF  = 2;

    typedef struct packed {
        logic ovf;
        logic done;
        logic busy;
    } csr_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ntt_bram_rd_pipe.sv
// RD_LAT-deep read data/valid delay line; the output register only updates when
// a read emerges, so read data holds between reads.
module ntt_bram_rd_pipe #(
    parameter int W      = 64,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q;
    logic [W-1:0]      dat_q [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            out_data <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) dat_q[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            if (vld_q[RD_LAT-1]) out_data <= dat_q[RD_LAT-1];
        end
    end

endmodule

// File: rtl/ntt_bram_responder.sv
// BRAM-port responder: 1024x64 store with the top word decoded as a command/status
// mailbox. Optional parity checking when NTT_BRAM_PARITY_EN is defined.
module ntt_bram_responder
    import ntt_bram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] BRAM_addr,
    input  logic [DATA_W-1:0] BRAM_din,
    output logic [DATA_W-1:0] BRAM_dout,
    input  logic              BRAM_en,
    input  logic              BRAM_we,
    output logic              cmd_valid,
    output logic [31:0]       cmd_data,
    input  logic              cmd_ready,
    input  logic              done_pulse,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`ifdef NTT_BRAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              csr_hit, rd_req, wr_req, csr_wr;
    logic              start_req, start_ok, start_drop;
    logic [DATA_W-1:0] rd_word;
    csr_t              csr_q;
    logic              unused_addr_bits;

    assign idx              = BRAM_addr[3 +: IDX_W];
    assign unused_addr_bits = ^BRAM_addr[2:0];
    assign csr_hit          = (idx == IDX_W'(CSR_WORD_IDX));
    assign rd_req           = BRAM_en & ~BRAM_we;
    assign wr_req           = BRAM_en & BRAM_we;
    assign csr_wr           = wr_req & csr_hit;
    assign start_req        = csr_wr & BRAM_din[CSR_START];
    assign start_ok         = start_req & ~cmd_valid;
    assign start_drop       = start_req & cmd_valid;

    always_comb begin
        rd_word = mem[idx];
        if (csr_hit) rd_word = {cmd_data, {(DATA_W-35){1'b0}}, csr_q};
    end

    always_ff @(posedge clk) begin
        if (wr_req && !csr_hit) mem[idx] <= BRAM_din;
    end

    ntt_bram_rd_pipe #(.W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_req),
        .in_data  (rd_word),
        .out_data (BRAM_dout)
    );

    // Mailbox: completion set beats a same-edge W1C, and a new start beats a same-edge done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            csr_q     <= '0;
        end else begin
            if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
            if (start_ok) begin
                cmd_valid <= 1'b1;
                cmd_data  <= BRAM_din[DATA_W-1 -: 32];
            end

            if (start_ok)        csr_q.busy <= 1'b1;
            else if (done_pulse) csr_q.busy <= 1'b0;

            if (done_pulse)                             csr_q.done <= 1'b1;
            else if (csr_wr && BRAM_din[CSR_W1C_DONE])  csr_q.done <= 1'b0;

            if (start_drop)                             csr_q.ovf <= 1'b1;
            else if (csr_wr && BRAM_din[CSR_W1C_OVF])   csr_q.ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_req) rd_count <= sat_inc(rd_count);
            if (wr_req) wr_count <= sat_inc(wr_count);
        end
    end

`ifdef NTT_BRAM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_req && !csr_hit) mem_par[idx] <= ^BRAM_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else if (rd_req && !csr_hit && ((^mem[idx]) != mem_par[idx])) parity_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ntt_bram_responder.sv
// Self-checking bench for ntt_bram_responder: randomized traffic against a
// behavioural model of the store, mailbox and read latency.
module tb_ntt_bram_responder;

    localparam int RD_LAT = 1;
    localparam logic [12:0] CSR_ADDR = 13'h1FF8;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] addr;
    logic [63:0] din;
    logic [63:0] dout;
    logic        en, we, cmd_ready, done_pulse;
    logic        cmd_valid;
    logic [31:0] cmd_data, rd_count, wr_count;
`ifdef NTT_BRAM_PARITY_EN
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ntt_bram_responder #(.RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .BRAM_addr  (addr),
        .BRAM_din   (din),
        .BRAM_dout  (dout),
        .BRAM_en    (en),
        .BRAM_we    (we),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .done_pulse (done_pulse),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`ifdef NTT_BRAM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model
    typedef struct { bit v; logic [63:0] d; } rd_ent_t;
    logic [63:0] m_mem [1024];
    bit          m_written [1024];
    int          m_wlist[$];
    rd_ent_t     m_pipe[$];
    logic [63:0] m_dout;
    logic        m_cv, m_busy, m_done, m_ovf;
    logic [31:0] m_cd;
    logic [31:0] m_rd, m_wr;

    task automatic model_reset();
        rd_ent_t e;
        e.v = 0; e.d = '0;
        m_pipe = {};
        for (int i = 0; i < RD_LAT; i++) m_pipe.push_back(e);
        m_dout = '0; m_cv = 0; m_cd = '0;
        m_busy = 0; m_done = 0; m_ovf = 0;
        m_rd = '0; m_wr = '0;
    endtask

    task automatic model_edge();
        int      i = int'(addr[12:3]);
        bit      csr = (i == 1023);
        bit      csr_wr = en && we && csr;
        bit      acc = csr_wr && din[0] && !m_cv;
        bit      drop = csr_wr && din[0] && m_cv;
        rd_ent_t e, old;
        e.v = en && !we;
        e.d = csr ? {m_cd, 29'b0, m_ovf, m_done, m_busy} : m_mem[i];
        old = m_pipe.pop_front();
        if (old.v) m_dout = old.d;
        m_pipe.push_back(e);
        if (en && !we && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
        if (en && we && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
        if (en && we && !csr) begin
            m_mem[i] = din;
            if (!m_written[i]) begin m_written[i] = 1; m_wlist.push_back(i); end
        end
        if (m_cv && cmd_ready) m_cv = 0;
        if (acc) begin m_cv = 1; m_cd = din[63:32]; end
        if (acc) m_busy = 1; else if (done_pulse) m_busy = 0;
        if (done_pulse) m_done = 1; else if (csr_wr && din[1]) m_done = 0;
        if (drop) m_ovf = 1; else if (csr_wr && din[2]) m_ovf = 0;
    endtask

    task automatic cycle(input bit e, input bit w, input logic [12:0] a, input logic [63:0] d,
                         input bit rdy, input bit dp);
        en = e; we = w; addr = a; din = d; cmd_ready = rdy; done_pulse = dp;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(); cycle(0, 0, '0, '0, 0, 0); endtask

    task automatic read_csr(output logic [63:0] v);
        cycle(1, 0, CSR_ADDR, '0, 0, 0);
        for (int k = 0; k < RD_LAT; k++) idle();
        v = dout;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; we = 0; addr = '0; din = '0; cmd_ready = 0; done_pulse = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (dout !== 64'd0) begin n_errors++; $display("FAIL reset_dout got %h want 0", dout); end
        n_checks++; if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        n_checks++; if (cmd_data !== 32'd0) begin n_errors++; $display("FAIL reset_cmd_data got %h want 0", cmd_data); end
        n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            n_errors++; $display("FAIL reset_counts got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
    endtask

    task automatic test_write_read();
        cycle(1, 1, 13'h0010, 64'h0123_4567_89AB_CDEF, 0, 0);
        cycle(1, 0, 13'h0010, '0, 0, 0);
        n_checks++; if (dout !== 64'd0) begin n_errors++; $display("FAIL wr_rd_early got %h want 0", dout); end
        for (int k = 1; k < RD_LAT; k++) idle();
        idle();
        n_checks++; if (dout !== 64'h0123_4567_89AB_CDEF) begin
            n_errors++; $display("FAIL wr_rd_data got %h want 0123456789abcdef", dout); end
        for (int k = 0; k < 5; k++) begin
            idle();
            n_checks++; if (dout !== 64'h0123_4567_89AB_CDEF) begin
                n_errors++; $display("FAIL wr_rd_hold cyc%0d got %h want 0123456789abcdef", k, dout); end
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 1, 13'(i * 8), 64'(i * 3), 0, 0);
        for (int c = 0; c < 8 + RD_LAT; c++) begin
            if (c < 8) cycle(1, 0, 13'(c * 8), '0, 0, 0);
            else idle();
            n_checks++;
            if (c < RD_LAT) begin
                if (dout !== 64'd0) begin n_errors++; $display("FAIL stream_pre c%0d got %h want 0", c, dout); end
            end else if (dout !== 64'((c - RD_LAT) * 3)) begin
                n_errors++; $display("FAIL stream c%0d got %0d want %0d", c, dout, (c - RD_LAT) * 3);
            end
        end
        n_checks++; if (rd_count !== 32'd8) begin n_errors++; $display("FAIL stream_rd_count got %0d want 8", rd_count); end
        n_checks++; if (wr_count !== 32'd8) begin n_errors++; $display("FAIL stream_wr_count got %0d want 8", wr_count); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            int op = $urandom_range(0, 4);
            int i;
            if (op == 0 || m_wlist.size() == 0) begin
                i = $urandom_range(0, 1022);
                cycle(1, 1, {10'(i), 3'($urandom)}, {$urandom, $urandom}, 0, 0);
            end else if (op == 1) begin
                idle();
            end else if (op == 2) begin
                i = $urandom_range(0, 1022);
                cycle(1, 1, {10'(i), 3'b0}, {$urandom, $urandom}, 0, 0);
                if (m_dout !== dout) bad++;
                cycle(1, 0, {10'(i), 3'($urandom)}, '0, 0, 0);
            end else begin
                i = m_wlist[$urandom_range(0, m_wlist.size() - 1)];
                cycle(1, 0, {10'(i), 3'($urandom)}, '0, 0, 0);
            end
            n_checks++;
            if (dout !== m_dout) begin
                n_errors++; bad++;
                if (bad < 5) $display("FAIL random_dout n%0d got %h want %h", n, dout, m_dout);
            end
        end
        for (int k = 0; k < RD_LAT; k++) idle();
        n_checks++; if (dout !== m_dout) begin n_errors++; $display("FAIL random_tail got %h want %h", dout, m_dout); end
        n_checks++; if (rd_count !== m_rd || wr_count !== m_wr) begin
            n_errors++; $display("FAIL random_counts got rd=%0d wr=%0d want %0d/%0d", rd_count, wr_count, m_rd, m_wr); end
    endtask

    task automatic test_cmd();
        logic [63:0] v;
        cycle(1, 1, CSR_ADDR, 64'hDEAD_BEEF_0000_0001, 0, 0);
        n_checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL cmd_issue got v=%b d=%h want 1/deadbeef", cmd_valid, cmd_data); end
        for (int k = 0; k < 4; k++) begin
            idle();
            n_checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hDEADBEEF) begin
                n_errors++; $display("FAIL cmd_stall c%0d got v=%b d=%h want 1/deadbeef", k, cmd_valid, cmd_data); end
        end
        cycle(0, 0, '0, '0, 1, 0);
        n_checks++; if (cmd_valid !== m_cv || cmd_valid !== 1'b0) begin
            n_errors++; $display("FAIL cmd_accept got v=%b want 0", cmd_valid); end
        read_csr(v);
        n_checks++; if (v !== 64'hDEAD_BEEF_0000_0001 || v !== m_dout) begin
            n_errors++; $display("FAIL cmd_csr got %h want deadbeef00000001", v); end
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        cycle(1, 1, CSR_ADDR, 64'h1111_1111_0000_0001, 0, 0);
        cycle(1, 1, CSR_ADDR, 64'h2222_2222_0000_0001, 0, 0);
        n_checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'h1111_1111) begin
            n_errors++; $display("FAIL ovf_keep got v=%b d=%h want 1/11111111", cmd_valid, cmd_data); end
        read_csr(v);
        n_checks++; if (v !== 64'h1111_1111_0000_0005) begin
            n_errors++; $display("FAIL ovf_set got %h want 1111111100000005", v); end
        cycle(1, 1, CSR_ADDR, 64'h4, 0, 0);
        read_csr(v);
        n_checks++; if (v !== 64'h1111_1111_0000_0001) begin
            n_errors++; $display("FAIL ovf_clr got %h want 1111111100000001", v); end
        cycle(0, 0, '0, '0, 1, 0);
        n_checks++; if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drain got %b want 0", cmd_valid); end
    endtask

    task automatic test_done();
        logic [63:0] v;
        cycle(0, 0, '0, '0, 0, 1);
        read_csr(v);
        n_checks++; if (v[2:0] !== 3'b010) begin n_errors++; $display("FAIL done_set got %b want 010", v[2:0]); end
        cycle(1, 1, CSR_ADDR, 64'h2, 0, 1);
        read_csr(v);
        n_checks++; if (v[2:0] !== 3'b010) begin n_errors++; $display("FAIL done_race got %b want 010", v[2:0]); end
        cycle(1, 1, CSR_ADDR, 64'h2, 0, 0);
        read_csr(v);
        n_checks++; if (v[2:0] !== 3'b000) begin n_errors++; $display("FAIL done_w1c got %b want 000", v[2:0]); end
        cycle(1, 1, CSR_ADDR, 64'h3333_3333_0000_0001, 0, 1);
        read_csr(v);
        n_checks++; if (v !== 64'h3333_3333_0000_0003 || v !== m_dout) begin
            n_errors++; $display("FAIL done_start got %h want 3333333300000003", v); end
        cycle(0, 0, '0, '0, 1, 0);
    endtask

    task automatic test_reset_mid();
        cycle(1, 1, 13'h0100, 64'hAAAA_5555_0000_1111, 0, 0);
        cycle(1, 1, 13'h0108, 64'h5555_AAAA_2222_0000, 0, 0);
        cycle(1, 1, CSR_ADDR, 64'h7777_0000_0000_0001, 0, 0);
        cycle(1, 0, 13'h0100, '0, 0, 0);
        for (int k = 0; k < RD_LAT; k++) idle();
        n_checks++; if (dout !== 64'hAAAA_5555_0000_1111) begin
            n_errors++; $display("FAIL mid_pre got %h want aaaa555500001111", dout); end
        cycle(1, 0, 13'h0108, '0, 0, 0);
        en = 0;
        #2 rst = 1;
        #1;
        n_checks++; if (dout !== 64'd0) begin n_errors++; $display("FAIL mid_dout got %h want 0", dout); end
        n_checks++; if (cmd_valid !== 1'b0 || cmd_data !== 32'd0) begin
            n_errors++; $display("FAIL mid_cmd got v=%b d=%h want 0/0", cmd_valid, cmd_data); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int k = 0; k < RD_LAT + 1; k++) idle();
        n_checks++; if (dout !== 64'd0) begin n_errors++; $display("FAIL mid_discard got %h want 0", dout); end
        n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            n_errors++; $display("FAIL mid_counts got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
        cycle(1, 0, 13'h0108, '0, 0, 0);
        for (int k = 0; k < RD_LAT; k++) idle();
        n_checks++; if (dout !== 64'h5555_AAAA_2222_0000) begin
            n_errors++; $display("FAIL mid_array got %h want 5555aaaa22220000", dout); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_written[i] = 0;
        test_reset();
        test_write_read();
        test_stream();
        test_random();
        test_cmd();
        test_overflow();
        test_done();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ntt_bram_responder.md
Name: ntt_bram_responder

Overview:
- Responder (slave) end of the 64-bit native BRAM port that the NTT BRAM initiator drives: addr / din / dout / en / we.
- Backs a 1024x64 coefficient store.
- The top word is decoded as a control/status mailbox. Writes to it hand a command to a local consumer through a valid/ready handshake; the consumer reports completion back through the same word.
- Used as a synthesizable stand-in for the block-design BRAM in simulation and standalone bring-up.

Parameters:
- ADDR_W, 13, BRAM byte-address width.
- DATA_W, 64, data width; a word is 8 bytes.
- DEPTH, 1024, number of words; word index = BRAM_addr[12:3].
- RD_LAT, 1, read latency in clk cycles; legal values 1 or 2.

Ports:
- clk  in  1  sole clock. The initiator's BRAM_clk is tied to this at integration; it is not a port.
- rst  in  1  asynchronous, active-high reset.
- BRAM_addr  in  ADDR_W  byte address; bits [2:0] ignored.
- BRAM_din  in  DATA_W  write data.
- BRAM_dout  out  DATA_W  read data.
- BRAM_en  in  1  access enable.
- BRAM_we  in  1  write enable, full word; qualified by BRAM_en.
- cmd_valid  out  1  mailbox command pending.
- cmd_data  out  32  command payload.
- cmd_ready  in  1  consumer accepts the command.
- done_pulse  in  1  consumer completion strobe; one cycle.
- rd_count  out  32  accepted reads, saturating.
- wr_count  out  32  accepted writes, saturating.

Behaviour:
- Reset (async assert, sync release): BRAM_dout=0, cmd_valid=0, cmd_data=0, CSR=0, counters=0, read pipeline cleared. Array contents are not reset; reads of unwritten words are undefined.
- Word 1023 (byte 0x1FF8) is the CSR. All other words are plain storage.

Accesses:
- Access occurs on a rising edge with BRAM_en=1.
- Write (we=1): mem[idx] <= BRAM_din. BRAM_dout is unchanged (NO_CHANGE mode). wr_count increments.
- Read (we=0): BRAM_dout presents the data RD_LAT edges later and holds it until the next completed read. rd_count increments.
- Back-to-back reads every cycle are supported with no bubbles.
- A read following a write to the same address on the next cycle returns the new data.
- en=0: no state change; BRAM_dout holds its value.

CSR write:
- din[0]=1 (start):
  - If cmd_valid=0: set cmd_valid, capture cmd_data <= din[63:32], set busy.
  - If cmd_valid=1: command dropped, cmd_data unchanged, sticky overflow set.
- din[1]=1 clears done (W1C).
- din[2]=1 clears overflow (W1C).

CSR read data: {din-captured cmd_data[31:0], 29'b0, overflow, done, busy}.

Command handshake:
- cmd_valid and cmd_data are stable until cmd_valid & cmd_ready on an edge; cmd_valid then drops the next cycle.
- cmd_ready while cmd_valid=0 is ignored.

Completion:
- done_pulse clears busy and sets done.
- If a done_pulse and a done-W1C write land on the same edge, set wins (done=1).
- A start accepted on the same edge as done_pulse leaves busy=1, done=1.

Counters:
- 32-bit, saturate at 0xFFFF_FFFF.

Reset mid-operation: pending read data is discarded and BRAM_dout=0 immediately.

Optional Feature:
- NTT_BRAM_PARITY_EN defined:
  - Array stores an extra even-parity bit per word, computed on write.
  - Parity is checked on read.
  - On mismatch, the sticky output parity_err (1 bit) is set; it clears only on rst.
  - The bench can flip a stored parity bit through a hierarchical force.
- Undefined: no parity storage, no parity_err port.

Decomposition:
- Package ntt_bram_pkg:
  - ADDR_W/DATA_W defaults.
  - CSR_WORD_IDX = 1023.
  - CSR bit-position constants: BUSY=0, DONE=1, OVF=2; START=0 and the W1C bits on write.
  - Typedef csr_t (packed struct of status bits).
- One sub-module ntt_bram_rd_pipe: RD_LAT-deep read-data/valid delay line with reset, holding output between reads.

Test Plan:
- Write 0x0123_4567_89AB_CDEF to byte 0x0010, read 0x0010 next cycle: dout = that value exactly RD_LAT cycles after the read edge. Then en=0 for 5 cycles: dout holds.
- Stream reads of addrs 0x0000..0x0038 every cycle after filling word i with i*3: dout sequence 0,3,...,21 with no gaps. rd_count = 8.
- Write 0xDEAD_BEEF_0000_0001 to 0x1FF8: cmd_valid=1, cmd_data=0xDEADBEEF. Hold cmd_ready=0 for 4 cycles: outputs stable. cmd_ready=1: cmd_valid=0 next cycle. CSR read = busy=1.
- Start while pending: overflow=1, cmd_data unchanged. Write din=0x4: overflow cleared.
- done_pulse: CSR reads done=1, busy=0. done_pulse coincident with done-W1C write: done stays 1.
- Assert rst mid-read and mid-handshake: dout=0, cmd_valid=0 asynchronously; counters 0 after release.
